// File: rtl/motor_ramp_pkg.sv
// Shared types and constants for the motor arming / slew stage.
// Imported by the interface, the slew limiter and the top level.
package motor_pkg;

  localparam int SPD_W = 11;

  typedef logic [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {
    OFF,
    ARM,
    RUN,
    SPINDN
  } motor_state_t;

  localparam spd_t SPD_IDLE = 11'h000;

endpackage

// File: rtl/motor_ramp_if.sv
// Command/status bundle between the flight controller side and motor_ramp.
// master drives arm/kill/commands, slave returns speeds and qualifiers.
interface motor_ramp_if;
  import motor_pkg::*;

  logic arm_req;
  logic kill;
  spd_t frnt_cmd;
  spd_t bck_cmd;
  spd_t lft_cmd;
  spd_t rght_cmd;
  spd_t frnt_spd;
  spd_t bck_spd;
  spd_t lft_spd;
  spd_t rght_spd;
  logic motors_off;
  logic armed;

  modport master (
    output arm_req, kill,
    output frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    input  frnt_spd, bck_spd, lft_spd, rght_spd,
    input  motors_off, armed
  );

  modport slave (
    input  arm_req, kill,
    input  frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    output frnt_spd, bck_spd, lft_spd, rght_spd,
    output motors_off, armed
  );

endinterface

// File: rtl/motor_ramp_slew_lim.sv
// Per-motor slew limiter: moves toward target by at most STEP per tick,
// snapping onto the target once within STEP; clr zeroes at once.
module slew_lim
  import motor_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  input  spd_t target,
  output spd_t spd
);

  localparam logic [SPD_W:0] STEP_X = (SPD_W+1)'(STEP);
  localparam spd_t           STEP_S = SPD_W'(STEP);

  spd_t spd_q;
  spd_t spd_d;
  logic signed [SPD_W:0] diff;
  logic [SPD_W:0] mag;

  always_comb begin
    diff  = $signed({1'b0, target}) - $signed({1'b0, spd_q});
    mag   = diff[SPD_W] ? $unsigned(-diff) : $unsigned(diff);
    spd_d = spd_q;
    if (clr) begin
      spd_d = SPD_IDLE;
    end else if (tick) begin
      if (mag <= STEP_X)    spd_d = target;
      else if (diff[SPD_W]) spd_d = spd_q - STEP_S;
      else                  spd_d = spd_q + STEP_S;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) spd_q <= SPD_IDLE;
    else     spd_q <= spd_d;
  end

  assign spd = spd_q;

endmodule

// File: rtl/motor_ramp.sv
// Arm -> hold -> run -> spin-down sequencer with per-motor slew limiting
// feeding the four-motor ESC block.
module motor_ramp
  import motor_pkg::*;
#(
  parameter int RAMP_DIV = 4096,
  parameter int STEP     = 8,
  parameter int ARM_CYC  = 1 << 20
) (
  input logic clk,
  input logic rst,
  motor_ramp_if.slave bus
);

  localparam int ACW = $clog2(ARM_CYC);
  localparam int TCW = $clog2(RAMP_DIV);
  localparam logic [ACW-1:0] ARM_LAST  = ACW'(ARM_CYC - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(RAMP_DIV - 1);

  motor_state_t state_q, state_d;
  logic [ACW-1:0] arm_cnt_q, arm_cnt_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic motors_off_q, motors_off_d;
  logic armed_q, armed_d;
  logic spin_q, spin_d;
  logic tick, clr, all_zero;
  spd_t cmd [4];
  spd_t tgt [4];
  spd_t spd [4];

  assign cmd[0] = bus.frnt_cmd;
  assign cmd[1] = bus.bck_cmd;
  assign cmd[2] = bus.lft_cmd;
  assign cmd[3] = bus.rght_cmd;

  assign all_zero = (spd[0] == SPD_IDLE) && (spd[1] == SPD_IDLE) &&
                    (spd[2] == SPD_IDLE) && (spd[3] == SPD_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF: if (bus.arm_req) state_d = ARM;
      ARM: begin
        if (!bus.arm_req)            state_d = OFF;
        else if (arm_cnt_q == ARM_LAST) state_d = RUN;
      end
      RUN: if (!bus.arm_req) state_d = SPINDN;
      SPINDN: begin
        if (bus.arm_req) state_d = RUN;
        else if (all_zero) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
    // Kill overrides every other transition.
    if (bus.kill) state_d = OFF;
  end

  always_comb begin
    spin_q = (state_q == RUN) || (state_q == SPINDN);
    spin_d = (state_d == RUN) || (state_d == SPINDN);
    tick   = spin_q && (tick_cnt_q == TICK_LAST);
    clr    = !spin_d;

    tick_cnt_d = '0;
    if (spin_q && spin_d && !tick) tick_cnt_d = tick_cnt_q + 1'b1;

    arm_cnt_d = '0;
    if (state_q == ARM && state_d == ARM) arm_cnt_d = arm_cnt_q + 1'b1;

    motors_off_d = (state_d == OFF);
    armed_d      = spin_d;

    for (int i = 0; i < 4; i++) begin
      tgt[i] = (state_q == RUN) ? cmd[i] : SPD_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OFF;
      arm_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      motors_off_q <= 1'b1;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      motors_off_q <= motors_off_d;
      armed_q      <= armed_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_slew
    slew_lim #(
      .STEP (STEP)
    ) u_slew (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .clr    (clr),
      .target (tgt[g]),
      .spd    (spd[g])
    );
  end

  assign bus.frnt_spd   = spd[0];
  assign bus.bck_spd    = spd[1];
  assign bus.lft_spd    = spd[2];
  assign bus.rght_spd   = spd[3];
  assign bus.motors_off = motors_off_q;
  assign bus.armed      = armed_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Bench for motor_ramp: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_motor_ramp;

  localparam int RD = 4;
  localparam int ST = 8;
  localparam int AC = 16;

  localparam int S_OFF = 0;
  localparam int S_ARM = 1;
  localparam int S_RUN = 2;
  localparam int S_SPD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motor_ramp_if bus ();

  motor_ramp #(
    .RAMP_DIV (RD),
    .STEP     (ST),
    .ARM_CYC  (AC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit go     = 0;

  int m_st   = S_OFF;
  int m_acnt = 0;
  int m_tcnt = 0;
  int m_spd [4] = '{0, 0, 0, 0};

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int cmd_of(int i);
    case (i)
      0: return int'(bus.frnt_cmd);
      1: return int'(bus.bck_cmd);
      2: return int'(bus.lft_cmd);
      default: return int'(bus.rght_cmd);
    endcase
  endfunction

  // Model: state advances per the sequencing rules; speeds move by
  // plain integer arithmetic once every RD clocks while spinning.
  always @(posedge clk) begin : model
    int nst;
    bit tk;
    bit zero;
    int tgt;
    int d;
    if (rst) begin
      m_st = S_OFF;
      m_acnt = 0;
      m_tcnt = 0;
      for (int i = 0; i < 4; i++) m_spd[i] = 0;
    end else begin
      tk = (m_st >= S_RUN) && (m_tcnt == RD - 1);
      zero = (m_spd[0] + m_spd[1] + m_spd[2] + m_spd[3]) == 0;
      nst = m_st;
      case (m_st)
        S_OFF: if (bus.arm_req) nst = S_ARM;
        S_ARM: nst = !bus.arm_req ? S_OFF :
                     (m_acnt == AC - 1) ? S_RUN : S_ARM;
        S_RUN: if (!bus.arm_req) nst = S_SPD;
        default: nst = bus.arm_req ? S_RUN : (zero ? S_OFF : S_SPD);
      endcase
      if (bus.kill) nst = S_OFF;
      for (int i = 0; i < 4; i++) begin
        if (nst < S_RUN) m_spd[i] = 0;
        else if (tk) begin
          tgt = (m_st == S_RUN) ? cmd_of(i) : 0;
          d = tgt - m_spd[i];
          if (d <= ST && d >= -ST) m_spd[i] = tgt;
          else m_spd[i] = m_spd[i] + ((d > 0) ? ST : -ST);
        end
      end
      m_acnt = (m_st == S_ARM && nst == S_ARM) ? m_acnt + 1 : 0;
      m_tcnt = (m_st >= S_RUN && nst >= S_RUN) ? (m_tcnt + 1) % RD : 0;
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      check("cycle",
        64'({bus.frnt_spd, bus.bck_spd, bus.lft_spd, bus.rght_spd,
             bus.motors_off, bus.armed}),
        64'({11'(m_spd[0]), 11'(m_spd[1]), 11'(m_spd[2]), 11'(m_spd[3]),
             m_st == S_OFF, m_st >= S_RUN}));
    end
  end

  task automatic ticks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(string nm, int act, int exp);
    check(nm, 64'(act), 64'(exp));
  endtask

  function automatic int spd_sum();
    return int'(bus.frnt_spd) + int'(bus.bck_spd) +
           int'(bus.lft_spd) + int'(bus.rght_spd);
  endfunction

  task automatic set_cmds(int f, int b, int l, int r);
    bus.frnt_cmd = 11'(f);
    bus.bck_cmd  = 11'(b);
    bus.lft_cmd  = 11'(l);
    bus.rght_cmd = 11'(r);
  endtask

  initial begin
    bus.arm_req = 1'($urandom);
    bus.kill    = 1'($urandom);
    set_cmds(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
    ticks(2);
    pin("rst_spd", spd_sum(), 0);
    pin("rst_off", int'(bus.motors_off), 1);
    pin("rst_armed", int'(bus.armed), 0);
    rst = 1'b0;
    bus.arm_req = 1'b0;
    bus.kill = 1'b0;
    set_cmds(0, 0, 0, 0);
    go = 1;
    ticks(1);

    // Arm aborted after 8 clocks.
    bus.arm_req = 1'b1;
    ticks(1);
    pin("arm_moff", int'(bus.motors_off), 0);
    ticks(7);
    bus.arm_req = 1'b0;
    ticks(1);
    pin("abort_off", int'(bus.motors_off), 1);
    pin("abort_armed", int'(bus.armed), 0);

    // Full arm.
    bus.arm_req = 1'b1;
    ticks(1);
    pin("arm2_moff", int'(bus.motors_off), 0);
    ticks(15);
    pin("arm_hold", int'(bus.armed), 0);
    pin("arm_spd0", spd_sum(), 0);
    ticks(1);
    pin("arm_done", int'(bus.armed), 1);

    // Ramp up.
    set_cmds(40, 5, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      ticks(4);
      pin("ramp_frnt", int'(bus.frnt_spd), 8 * i);
      if (i == 1) pin("ramp_bck", int'(bus.bck_spd), 5);
    end
    bus.frnt_cmd = 11'd37;
    ticks(4);
    pin("retarget", int'(bus.frnt_spd), 37);
    bus.frnt_cmd = 11'd40;
    ticks(4);
    pin("back40", int'(bus.frnt_spd), 40);

    // Partial spin-down then resume without re-arm.
    bus.arm_req = 1'b0;
    ticks(4);
    pin("sd_32", int'(bus.frnt_spd), 32);
    ticks(8);
    pin("sd_16", int'(bus.frnt_spd), 16);
    bus.arm_req = 1'b1;
    ticks(1);
    pin("resume_moff", int'(bus.motors_off), 0);
    ticks(3);
    pin("resume_24", int'(bus.frnt_spd), 24);
    ticks(8);
    pin("resume_40", int'(bus.frnt_spd), 40);

    // Full spin-down; re-request on the all-zero clock.
    bus.arm_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ticks(4);
      pin("sd_frnt", int'(bus.frnt_spd), 40 - 8 * i);
    end
    bus.arm_req = 1'b1;
    ticks(1);
    pin("zero_rerun_moff", int'(bus.motors_off), 0);
    pin("zero_rerun_arm", int'(bus.armed), 1);
    set_cmds(0, 0, 0, 0);
    bus.arm_req = 1'b0;
    ticks(2);
    pin("sd_off", int'(bus.motors_off), 1);
    pin("sd_off_armed", int'(bus.armed), 0);

    // Ramp to full scale, then kill.
    set_cmds(2047, 2047, 2047, 2047);
    bus.arm_req = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (bus.frnt_spd == 11'd2047) break;
      ticks(1);
    end
    pin("ramp_max", int'(bus.frnt_spd), 2047);
    bus.kill = 1'b1;
    ticks(1);
    pin("kill_spd", spd_sum(), 0);
    pin("kill_off", int'(bus.motors_off), 1);
    ticks(3);
    pin("kill_hold", int'(bus.motors_off), 1);
    bus.kill = 1'b0;
    ticks(1);
    pin("rearm_moff", int'(bus.motors_off), 0);
    ticks(15);
    pin("rearm_hold", int'(bus.armed), 0);
    ticks(1);
    pin("rearm_done", int'(bus.armed), 1);

    // Kill on the arm-complete clock.
    bus.kill = 1'b1;
    ticks(1);
    bus.kill = 1'b0;
    ticks(16);
    bus.kill = 1'b1;
    ticks(1);
    pin("kill_armdone_off", int'(bus.motors_off), 1);
    pin("kill_armdone_arm", int'(bus.armed), 0);

    // arm_req falling on the arm-complete clock.
    bus.kill = 1'b0;
    ticks(16);
    bus.arm_req = 1'b0;
    ticks(1);
    pin("drop_armdone_off", int'(bus.motors_off), 1);
    pin("drop_armdone_arm", int'(bus.armed), 0);

    // Reset mid-ramp.
    bus.arm_req = 1'b1;
    ticks(17);
    ticks(12);
    pin("pre_rst_24", int'(bus.frnt_spd), 24);
    rst = 1'b1;
    ticks(1);
    pin("midrst_spd", spd_sum(), 0);
    pin("midrst_off", int'(bus.motors_off), 1);
    rst = 1'b0;
    bus.arm_req = 1'b0;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/motor_ramp.md
# motor_ramp

Arming and slew-rate stage that sits directly upstream of the four-motor ESC block. It takes the raw per-motor speed commands from the flight controller and an operator arm request, then runs an arm → hold → run → spin-down sequence. It produces the `motors_off` qualifier and the four slew-limited 11-bit speeds that the ESC block consumes. Motor speeds never step: they ramp at a bounded rate, and a kill input cuts all motors within one clock.

## Interface
- `RAMP_DIV`, default 4096: clocks per slew tick (≥2).
- `STEP`, default 8: max speed change per tick, in LSBs (1..255).
- `ARM_CYC`, default 2^20: clocks spent in ARM with the ESCs idling before RUN (≥2).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: **reset is synchronous and active-high; single clock domain.**
- `arm_req` in 1: level; high requests motors on.
- `kill` in 1: level; emergency stop, highest priority.
- `frnt_cmd`, `bck_cmd`, `lft_cmd`, `rght_cmd` in 11 each: unsigned target speeds.
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd` out 11 each: slew-limited speeds to the ESCs.
- `motors_off` out 1: high forces the ESCs fully off.
- `armed` out 1: high in RUN and SPINDN.

## Operation
- States are OFF, ARM, RUN and SPINDN. All outputs are registered.
- **Reset:** state=OFF; all `*_spd`=0; `motors_off`=1; `armed`=0; arm and tick counters cleared.
- **`kill` high:** from any state, the next state is OFF and all speeds are 0. While `kill` is high the block stays in OFF.
- **OFF:** `motors_off`=1, speeds 0. Goes to ARM when `arm_req` is high and `kill` is low.
- **ARM:** `motors_off`=0, speeds held at 0 so the ESCs see the idle pulse only. The arm counter increments each clock.
  - `arm_req` low → OFF, counter cleared.
  - Counter reaches `ARM_CYC`-1 → RUN.
- **RUN:** `armed`=1. On each tick, every motor moves independently toward its command:
  - if |cmd−spd| ≤ `STEP`, then spd=cmd;
  - otherwise spd ±= `STEP`.
  - `arm_req` low → SPINDN.
- **SPINDN:** the target for all four motors is 0, using the same slew rule.
  - `arm_req` high → RUN directly, with no re-arm.
  - All four speeds 0 → OFF.
- **Tick counter:** counts 0..`RAMP_DIV`-1 and wraps. Tick is asserted on the count of `RAMP_DIV`-1. The counter is held at 0 in OFF and ARM, so the first RUN tick occurs `RAMP_DIV` clocks after entering RUN.
- **Arithmetic:** difference is 12-bit signed. Results never leave 0..2047, so no wrap and no saturation logic is needed beyond the |diff| ≤ `STEP` snap.
- **Command changes:** a command change mid-ramp retargets on the next tick, with no restart.

## Timing
- Every state transition takes effect on the edge after its condition is sampled.
- `motors_off` falls 1 clock after `arm_req` rises from OFF.
- RUN is entered `ARM_CYC` clocks after entering ARM.
- A kill asserted at edge N gives zero speeds and `motors_off`=1 after edge N+1.
- Speed updates occur only on the tick edge. Between ticks, outputs hold.
- **Simultaneous events:**
  - `kill` beats everything.
  - `arm_req` falling on the same clock as ARM completion → OFF.
  - `arm_req` rising on the same clock SPINDN reaches all-zero → RUN.
- **Reset mid-ramp:** all speeds are 0 the next clock, with no ramp down.

## Structure
- **Package `motor_pkg`:**
  - `SPD_W`=11.
  - `motor_state_t` enum (OFF, ARM, RUN, SPINDN).
  - Reset/idle speed constant 11'h000.
- **Sub-module `slew_lim`:** one per motor, four instances.
  - Inputs: clk, rst, tick, clr, target, and `STEP` as a parameter.
  - Output: registered speed.
- **Top level:** holds the FSM, the arm counter and the tick counter. Sized at ~200 lines of RTL total.

## Test plan
All scenarios use `RAMP_DIV`=4, `STEP`=8, `ARM_CYC`=16.
1. **Reset:** assert `rst` for 2 clocks with random inputs → all speeds 0, `motors_off`=1, `armed`=0.
2. **Arm:** raise `arm_req` at clock 0 → `motors_off`=0 at clock 1; `armed`=1 at clock 17; speeds stay 0 throughout ARM. Repeat with `arm_req` dropped at clock 8 → OFF at clock 9, `armed` never set.
3. **Ramp up:** in RUN, `frnt_cmd`=40 and `bck_cmd`=5 → `frnt_spd` steps 8, 16, 24, 32, 40 on successive 4-clock ticks; `bck_spd` snaps to 5 on the first tick. Then set `frnt_cmd`=37 → `frnt_spd`=37 on the next tick.
4. **Spin-down:** with `frnt_spd`=40, drop `arm_req` → `frnt_spd` 32, 24, 16, 8, 0 per tick, then OFF with `motors_off`=1. Raising `arm_req` at `frnt_spd`=16 → RUN with no ARM phase; ramp resumes from 16.
5. **Kill:** pulse `kill` during RUN at `frnt_spd`=2047 → next clock all speeds 0 and `motors_off`=1. With `arm_req` held high, release `kill` → ARM re-entered and takes the full 16 clocks.
6. **Simultaneous events:** `kill` and the ARM-complete condition on the same clock → OFF. `arm_req` rising on the SPINDN all-zero clock → RUN.
